uart_fifo_io: RTL and testbench

Memory-mapped 115200-baud UART peripheral on the OPC5 system bus, decoded by the system at 0xFE08/0xFE09. It is driven directly by the CPU's data/address/rnw bus and by the system's uart chip-select. It contains a transmitter with a TX busy flag and a receiver that feeds a small RX FIFO, so the CPU can poll bytes without losing back-to-back characters.

---
 rtl/uart_fifo_io_if.sv | 9 +
 rtl/uart_fifo_io.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_uart_fifo_io.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_io_if.sv
// CPU bus strobes (chip select, direction, address bit 0) as seen by the UART.
interface uart_fifo_io_if;
    logic cs_b;
    logic rnw;
    logic a0;

    modport master (output cs_b, output rnw, output a0);
    modport slave  (input cs_b, input rnw, input a0);
endinterface

// File: rtl/uart_fifo_io.sv
// Memory-mapped UART: TX shifter with busy flag, RX deserialiser feeding a small FIFO,
// status/data words on a tri-stated 16-bit CPU bus.
module uart_fifo_io #(
    parameter int CLKS_PER_BIT = 278,
    parameter int RX_DEPTH     = 4
) (
    input  logic          clk,
    input  logic          reset_b,
    uart_fifo_io_if.slave bus,
    inout  wire  [15:0]   data,
    input  logic          rxd,
    output logic          txd
);
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CNT_FW = $clog2(RX_DEPTH + 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_FW-1:0] FULL      = CNT_FW'(RX_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Bus access decode: only the first cycle of a write acts, pops fire on the
    // edge that ends a data read, however long that read was held.
    logic data_rd;
    logic wr_first;
    logic tx_wr;
    logic ctrl_wr;
    logic pop_req;
    logic pop;
    logic prev_rd1_reg;
    logic prev_wr_reg;

    tx_state_t        tx_state_reg, tx_state_next;
    logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0]       tx_bit_reg, tx_bit_next;
    logic [7:0]       tx_shift_reg, tx_shift_next;
    logic             txd_reg, txd_next;

    logic             rx_meta_reg;
    logic             rxs_reg;
    rx_state_t        rx_state_reg, rx_state_next;
    logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]       rx_bit_reg, rx_bit_next;
    logic [7:0]       rx_shift_reg, rx_shift_next;
    logic             push_req;
    logic             frame_set;
    logic             push;

    logic [7:0]        mem [RX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_FW-1:0] count_reg;
    logic              overrun_reg, overrun_next;
    logic              framing_reg, framing_next;

    logic [4:0]  count5;
    logic [15:0] status_word;
    logic [15:0] head_word;
    logic [15:0] rd_word;
    logic        unused_hi;

    assign data_rd  = !bus.cs_b && bus.rnw && bus.a0;
    assign wr_first = !bus.cs_b && !bus.rnw && !prev_wr_reg;
    assign tx_wr    = wr_first && bus.a0 && (tx_state_reg == TX_IDLE);
    assign ctrl_wr  = wr_first && !bus.a0;
    assign pop_req  = prev_rd1_reg && !data_rd;
    assign pop      = pop_req && (count_reg != '0);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            prev_rd1_reg <= 1'b0;
            prev_wr_reg  <= 1'b0;
        end else begin
            prev_rd1_reg <= data_rd;
            prev_wr_reg  <= !bus.cs_b && !bus.rnw;
        end
    end

    // Transmitter
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        txd_next      = txd_reg;
        case (tx_state_reg)
            TX_IDLE: begin
                if (tx_wr) begin
                    tx_state_next = TX_START;
                    tx_cnt_next   = '0;
                    tx_shift_next = data[7:0];
                    txd_next      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_state_next = TX_DATA;
                    tx_cnt_next   = '0;
                    tx_bit_next   = 3'd0;
                    txd_next      = tx_shift_reg[0];
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next = '0;
                    if (tx_bit_reg == 3'd7) begin
                        tx_state_next = TX_STOP;
                        txd_next      = 1'b1;
                    end else begin
                        tx_bit_next   = tx_bit_reg + 1'b1;
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                        txd_next      = tx_shift_reg[1];
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_state_next = TX_IDLE;
                    tx_cnt_next   = '0;
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= 3'd0;
            tx_shift_reg <= 8'h00;
            txd_reg      <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            txd_reg      <= txd_next;
        end
    end

    assign txd = txd_reg;

    // Receiver: rxd is asynchronous, so it crosses two flops before any decision.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rx_meta_reg <= 1'b1;
            rxs_reg     <= 1'b1;
        end else begin
            rx_meta_reg <= rxd;
            rxs_reg     <= rx_meta_reg;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        push_req      = 1'b0;
        frame_set     = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (!rxs_reg) begin
                    rx_state_next = RX_START;
                    rx_cnt_next   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_reg == HALF_LAST) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = 3'd0;
                    rx_state_next = rxs_reg ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rxs_reg, rx_shift_reg[7:1]};
                    if (rx_bit_reg == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        rx_bit_next = rx_bit_reg + 1'b1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_state_next = RX_IDLE;
                    rx_cnt_next   = '0;
                    push_req      = rxs_reg;
                    frame_set     = !rxs_reg;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= 3'd0;
            rx_shift_reg <= 8'h00;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
        end
    end

    // A same-edge pop frees the slot, so a push into a full FIFO still lands.
    assign push = push_req && ((count_reg != FULL) || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= rx_shift_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Sticky error flags; a new event on the same edge as a clear takes priority.
    always_comb begin
        overrun_next = overrun_reg;
        framing_next = framing_reg;
        if (ctrl_wr && data[2]) begin
            overrun_next = 1'b0;
        end
        if (ctrl_wr && data[3]) begin
            framing_next = 1'b0;
        end
        if (push_req && !push) begin
            overrun_next = 1'b1;
        end
        if (frame_set) begin
            framing_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            overrun_reg <= 1'b0;
            framing_reg <= 1'b0;
        end else begin
            overrun_reg <= overrun_next;
            framing_reg <= framing_next;
        end
    end

    // Read mux and tri-state bus driver
    assign count5      = 5'(count_reg);
    assign status_word = {7'd0, count5, framing_reg, overrun_reg,
                          (tx_state_reg == TX_IDLE), (count_reg != '0)};
    assign head_word   = (count_reg != '0) ? {8'h00, mem[rd_ptr_reg]} : 16'h0000;
    assign rd_word     = bus.a0 ? head_word : status_word;
    assign data        = (!bus.cs_b && bus.rnw) ? rd_word : 16'hzzzz;

    assign unused_hi = ^data[15:8];
endmodule

// File: tb/tb_uart_fifo_io.sv
// Self-checking bench for uart_fifo_io: directed table, TX waveform, queue-model random run,
// and the full-FIFO push/pop coincidence case.
module tb_uart_fifo_io;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        rxd = 1'b1;
    logic        txd;
    wire  [15:0] data;
    logic [15:0] drv_val = 16'h0000;
    logic        drv_en = 1'b0;

    int n_err    = 0;
    int n_checks = 0;

    assign data = drv_en ? drv_val : 16'hzzzz;

    uart_fifo_io_if bus ();

    uart_fifo_io #(.CLKS_PER_BIT(CPB), .RX_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus.slave),
        .data    (data),
        .rxd     (rxd),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    // Reference model: the RX FIFO as a queue plus two sticky flags.
    logic [7:0] mq [$];
    bit m_ovr;
    bit m_frm;

    function automatic logic [15:0] m_status();
        return {7'd0, 5'(mq.size()), m_frm, m_ovr, 1'b1, (mq.size() != 0)};
    endfunction

    function automatic logic [15:0] m_head();
        return (mq.size() != 0) ? {8'h00, mq[0]} : 16'h0000;
    endfunction

    function automatic void m_rx(input logic [7:0] b, input bit stop);
        if (!stop) m_frm = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovr = 1'b1;
    endfunction

    function automatic void m_pop();
        if (mq.size() != 0) void'(mq.pop_front());
    endfunction

    function automatic void m_ctrl(input logic [15:0] v);
        if (v[2]) m_ovr = 1'b0;
        if (v[3]) m_frm = 1'b0;
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.cs_b = 1'b1;
        bus.rnw  = 1'b1;
        bus.a0   = 1'b0;
        drv_en   = 1'b0;
    endtask

    task automatic do_reset();
        idle_bus();
        rxd = 1'b1;
        reset_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_b = 1'b1;
        mq.delete();
        m_ovr = 1'b0;
        m_frm = 1'b0;
    endtask

    task automatic bus_write(input logic a0, input logic [15:0] v);
        @(posedge clk); #1;
        bus.cs_b = 1'b0; bus.rnw = 1'b0; bus.a0 = a0;
        drv_val = v; drv_en = 1'b1;
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic bus_read(input logic a0, input int len, output logic [15:0] v);
        @(posedge clk); #1;
        bus.cs_b = 1'b0; bus.rnw = 1'b1; bus.a0 = a0;
        @(negedge clk);
        v = data;
        repeat (len) @(posedge clk);
        #1 idle_bus();
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic send_frame(input logic [7:0] b, input bit stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
        if (!stop) begin
            repeat (2 * CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_sync(input logic [7:0] b, input bit stop);
        @(posedge clk); #1;
        send_frame(b, stop);
    endtask

    task automatic glitch();
        @(posedge clk); #1 rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    typedef enum int {OP_RX, OP_RXBAD, OP_RDS, OP_RDD, OP_WRC, OP_GLITCH} op_t;
    typedef struct {
        op_t         op;
        logic [15:0] val;
        logic [15:0] exp;
        int          len;
    } vec_t;

    localparam int NV = 24;
    vec_t vt [NV];

    logic [15:0] rd;
    logic [9:0]  tx_frame;
    logic        exp_bit;
    logic [7:0]  rb;
    logic [15:0] rv;
    int          push_k;
    int          sel;

    initial begin
        // Directed table: RX single byte, fill/overrun, framing and glitch.
        vt[0]  = '{OP_RX,     16'h005A, 16'h0000, 0};
        vt[1]  = '{OP_RDS,    16'h0000, 16'h0013, 1};
        vt[2]  = '{OP_RDD,    16'h0000, 16'h005A, 3};
        vt[3]  = '{OP_RDS,    16'h0000, 16'h0002, 1};
        vt[4]  = '{OP_RX,     16'h0001, 16'h0000, 0};
        vt[5]  = '{OP_RX,     16'h0002, 16'h0000, 0};
        vt[6]  = '{OP_RX,     16'h0003, 16'h0000, 0};
        vt[7]  = '{OP_RX,     16'h0004, 16'h0000, 0};
        vt[8]  = '{OP_RX,     16'h0005, 16'h0000, 0};
        vt[9]  = '{OP_RDS,    16'h0000, 16'h0047, 1};
        vt[10] = '{OP_RDD,    16'h0000, 16'h0001, 3};
        vt[11] = '{OP_RDD,    16'h0000, 16'h0002, 1};
        vt[12] = '{OP_RDD,    16'h0000, 16'h0003, 2};
        vt[13] = '{OP_RDD,    16'h0000, 16'h0004, 1};
        vt[14] = '{OP_RDD,    16'h0000, 16'h0000, 1};
        vt[15] = '{OP_RDS,    16'h0000, 16'h0006, 1};
        vt[16] = '{OP_WRC,    16'h0004, 16'h0000, 0};
        vt[17] = '{OP_RDS,    16'h0000, 16'h0002, 1};
        vt[18] = '{OP_RXBAD,  16'h0033, 16'h0000, 0};
        vt[19] = '{OP_RDS,    16'h0000, 16'h000A, 1};
        vt[20] = '{OP_GLITCH, 16'h0000, 16'h0000, 0};
        vt[21] = '{OP_RDS,    16'h0000, 16'h000A, 1};
        vt[22] = '{OP_WRC,    16'h0008, 16'h0000, 0};
        vt[23] = '{OP_RDS,    16'h0000, 16'h0002, 1};

        // Reset mid-frame, idle status, bus released when deselected.
        do_reset();
        bus_read(1'b0, 1, rd);
        check("reset_status", rd, 16'h0002);
        bus_write(1'b1, 16'h0000);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("midframe_txd_low", 16'(txd), 16'h0000);
        reset_b = 1'b0;
        #1 check("async_reset_txd", 16'(txd), 16'h0001);
        @(posedge clk); #1 reset_b = 1'b1;
        bus_read(1'b0, 1, rd);
        check("post_reset_status", rd, 16'h0002);
        @(posedge clk); #1;
        drv_val = 16'h5555; drv_en = 1'b1;
        @(negedge clk);
        check("bus_hiz_deselected", data, 16'h5555);
        drv_en = 1'b0;
        $display("txn reset/idle done");

        // TX 0xA5 watched cycle by cycle under a continuous status read.
        do_reset();
        tx_frame = {1'b1, 8'hA5, 1'b0};
        @(posedge clk); #1;
        bus.cs_b = 1'b0; bus.rnw = 1'b0; bus.a0 = 1'b1;
        drv_val = 16'h00A5; drv_en = 1'b1;
        @(posedge clk); #1;
        drv_en = 1'b0; bus.rnw = 1'b1; bus.a0 = 1'b0;
        for (int k = 0; k <= 10 * CPB + 4; k++) begin
            @(negedge clk);
            exp_bit = (k < 10 * CPB) ? tx_frame[k / CPB] : 1'b1;
            check($sformatf("tx_txd_c%0d", k), 16'(txd), 16'(exp_bit));
            if (k != 31) check($sformatf("tx_ready_c%0d", k), 16'(data[1]), 16'(k >= 10 * CPB));
            @(posedge clk); #1;
            if (k == 30) begin
                bus.rnw = 1'b0; bus.a0 = 1'b1; drv_val = 16'h003C; drv_en = 1'b1;
            end else begin
                drv_en = 1'b0; bus.rnw = 1'b1; bus.a0 = 1'b0;
            end
        end
        idle_bus();
        $display("txn tx 0xA5 frame done");

        // Table-driven directed vectors
        do_reset();
        for (int i = 0; i < NV; i++) begin
            $display("txn vec %0d op=%s val=%h", i, vt[i].op.name(), vt[i].val);
            case (vt[i].op)
                OP_RX:     send_sync(vt[i].val[7:0], 1'b1);
                OP_RXBAD:  send_sync(vt[i].val[7:0], 1'b0);
                OP_GLITCH: glitch();
                OP_WRC:    bus_write(1'b0, vt[i].val);
                OP_RDS: begin
                    bus_read(1'b0, vt[i].len, rd);
                    check($sformatf("vec%0d_status", i), rd, vt[i].exp);
                end
                OP_RDD: begin
                    bus_read(1'b1, vt[i].len, rd);
                    check($sformatf("vec%0d_data", i), rd, vt[i].exp);
                end
                default: ;
            endcase
        end

        // Random traffic against the queue model
        do_reset();
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3) begin
                rb = 8'($urandom);
                exp_bit = ($urandom_range(0, 7) != 0);
                $display("txn rnd %0d rx byte=%h stop=%0d", it, rb, exp_bit);
                send_sync(rb, exp_bit);
                m_rx(rb, exp_bit);
            end else if (sel <= 6) begin
                $display("txn rnd %0d data read", it);
                bus_read(1'b1, $urandom_range(1, 3), rd);
                check($sformatf("rnd%0d_data", it), rd, m_head());
                m_pop();
            end else if (sel <= 8) begin
                $display("txn rnd %0d status read", it);
                bus_read(1'b0, 1, rd);
                check($sformatf("rnd%0d_status", it), rd, m_status());
            end else begin
                rv = 16'($urandom);
                $display("txn rnd %0d control write %h", it, rv);
                bus_write(1'b0, rv);
                m_ctrl(rv);
            end
        end
        bus_read(1'b0, 1, rd);
        check("rnd_final_status", rd, m_status());

        // Locate the push edge relative to the start bit, then land a pop on it with a full FIFO.
        do_reset();
        push_k = 0;
        @(posedge clk); #1;
        fork
            send_frame(8'h11, 1'b1);
            begin
                bus.cs_b = 1'b0; bus.rnw = 1'b1; bus.a0 = 1'b0;
                for (int k = 1; k <= 200 && push_k == 0; k++) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (data[0]) push_k = k;
                end
                idle_bus();
            end
        join
        check("push_edge_found", 16'(push_k > 4), 16'h0001);
        if (push_k > 4) begin
            do_reset();
            for (int i = 1; i <= 4; i++) begin
                send_sync(8'(8'hB0 + i), 1'b1);
                m_rx(8'(8'hB0 + i), 1'b1);
            end
            bus_read(1'b0, 1, rd);
            check("full_status", rd, m_status());
            @(posedge clk); #1;
            fork
                send_frame(8'hB5, 1'b1);
                begin
                    repeat (push_k - 3) @(posedge clk);
                    #1;
                    bus.cs_b = 1'b0; bus.rnw = 1'b1; bus.a0 = 1'b1;
                    @(negedge clk);
                    rd = data;
                    repeat (2) @(posedge clk);
                    #1 idle_bus();
                end
            join
            check("coincide_read", rd, m_head());
            m_pop();
            m_rx(8'hB5, 1'b1);
            bus_read(1'b0, 1, rd);
            check("coincide_status", rd, m_status());
            for (int i = 0; i < 4; i++) begin
                bus_read(1'b1, 1, rd);
                check($sformatf("coincide_drain%0d", i), rd, m_head());
                m_pop();
            end
            $display("txn full push/pop coincidence done at edge %0d", push_k);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
